// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, return-address stack, RUN/HALT
// control and trap redirect for the single-cycle CPU.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         PCWre,
  input  logic [1:0]                   PCSrc,
  input  logic [WIDTH-1:0]             Branch_Imm,
  input  logic [25:0]                  Jump_Addr,
  input  logic [WIDTH-1:0]             Reg_Target,
  input  logic                         Call,
  input  logic                         Ret,
  input  logic                         Trap,
  input  logic                         Halt,
  input  logic                         Resume,
  output logic [WIDTH-1:0]             IAddr,
  output logic [WIDTH-1:0]             PC4,
  output logic [WIDTH-1:0]             EPC,
  output logic                         Halted,
  output logic [$clog2(RAS_DEPTH):0]   RAS_Count,
  output logic                         RAS_Underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_JMP = 2'b10;
  localparam logic [1:0] SRC_REG = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_top;
  logic [PTR_W-1:0] top_nxt;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_en;

  logic             advance;
  logic             push;
  logic             pop_req;
  logic             pop_hit;
  logic             ras_empty;
  logic             ras_full;

  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] ras_head;
  logic [WIDTH-1:0] next_pc;

  // Address arithmetic; everything wraps modulo 2^WIDTH.
  assign PC4           = IAddr + WIDTH'(4);
  assign branch_target = PC4 + (Branch_Imm << 2);
  assign jump_target   = {PC4[WIDTH-1:28], Jump_Addr, 2'b00};
  assign ras_head      = ras_mem[ras_top];

  assign ras_empty = (RAS_Count == '0);
  assign ras_full  = (RAS_Count == CNT_W'(RAS_DEPTH));

  // A normal advance is the only case in which the RAS or the target mux matter.
  assign advance = (state == ST_RUN) && PCWre && !Halt && !Trap;
  assign pop_req = advance && Ret && (PCSrc == SRC_REG);
  assign pop_hit = pop_req && !ras_empty;
  assign push    = advance && Call;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_pc = PC4;
    unique case (PCSrc)
      SRC_SEQ: next_pc = PC4;
      SRC_BR:  next_pc = branch_target;
      SRC_JMP: next_pc = jump_target;
      SRC_REG: next_pc = pop_hit ? ras_head : Reg_Target;
      default: next_pc = PC4;
    endcase
  end

  // RAS bookkeeping. A combined call+return on a non-empty stack swaps the
  // top entry in place; on an empty stack it degrades to a plain push.
  always_comb begin
    top_nxt   = ras_top;
    count_nxt = RAS_Count;
    wr_en     = 1'b0;
    wr_idx    = ras_top + PTR_W'(1);
    if (pop_hit && push) begin
      wr_en  = 1'b1;
      wr_idx = ras_top;
    end else if (pop_hit) begin
      top_nxt   = ras_top - PTR_W'(1);
      count_nxt = RAS_Count - CNT_W'(1);
    end else if (push) begin
      wr_en   = 1'b1;
      top_nxt = ras_top + PTR_W'(1);
      if (!ras_full) begin
        count_nxt = RAS_Count + CNT_W'(1);
      end
    end
  end

  // NOTE: the RAS storage has no reset; an entry is only read once the count says it was written.
  always_ff @(posedge CLK) begin
    if (Reset && wr_en) begin
      ras_mem[wr_idx] <= PC4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state         <= ST_RUN;
      IAddr         <= RESET_VECTOR;
      EPC           <= '0;
      Halted        <= 1'b0;
      ras_top       <= '0;
      RAS_Count     <= '0;
      RAS_Underflow <= 1'b0;
    end else if (Trap) begin
      state  <= ST_RUN;
      Halted <= 1'b0;
      EPC    <= IAddr;
      IAddr  <= TRAP_VECTOR;
    end else if (state == ST_HALT) begin
      if (Resume) begin
        state  <= ST_RUN;
        Halted <= 1'b0;
      end
    end else if (PCWre) begin
      if (Halt) begin
        state  <= ST_HALT;
        Halted <= 1'b1;
      end else begin
        IAddr     <= next_pc;
        ras_top   <= top_nxt;
        RAS_Count <= count_nxt;
        if (pop_req && ras_empty) begin
          RAS_Underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] Branch_Imm;
  logic [25:0] Jump_Addr;
  logic [31:0] Reg_Target;
  logic        Call;
  logic        Ret;
  logic        Trap;
  logic        Halt;
  logic        Resume;
  logic [31:0] IAddr;
  logic [31:0] PC4;
  logic [31:0] EPC;
  logic        Halted;
  logic [2:0]  RAS_Count;
  logic        RAS_Underflow;

  always #5 CLK = ~CLK;

  pc_unit #(
    .WIDTH(32),
    .RESET_VECTOR(RV),
    .TRAP_VECTOR(TV),
    .RAS_DEPTH(4)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .PCWre(PCWre),
    .PCSrc(PCSrc),
    .Branch_Imm(Branch_Imm),
    .Jump_Addr(Jump_Addr),
    .Reg_Target(Reg_Target),
    .Call(Call),
    .Ret(Ret),
    .Trap(Trap),
    .Halt(Halt),
    .Resume(Resume),
    .IAddr(IAddr),
    .PC4(PC4),
    .EPC(EPC),
    .Halted(Halted),
    .RAS_Count(RAS_Count),
    .RAS_Underflow(RAS_Underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural state, with the RAS as a bounded queue (oldest at front).
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_halted;
  logic        m_uflow;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_step();
    logic [31:0] pc4;
    logic [31:0] tgt;
    pc4 = m_pc + 32'd4;
    if (!Reset) begin
      m_pc = RV; m_epc = '0; m_halted = 1'b0; m_uflow = 1'b0;
      m_ras.delete();
    end else if (Trap) begin
      m_epc = m_pc; m_pc = TV; m_halted = 1'b0;
    end else if (m_halted) begin
      if (Resume) m_halted = 1'b0;
    end else if (PCWre) begin
      if (Halt) begin
        m_halted = 1'b1;
      end else begin
        case (PCSrc)
          2'd0:    tgt = pc4;
          2'd1:    tgt = pc4 + Branch_Imm * 32'd4;
          2'd2:    tgt = {pc4[31:28], Jump_Addr, 2'b00};
          default: tgt = (Ret && m_ras.size() > 0) ? m_ras[$] : Reg_Target;
        endcase
        if (Ret && PCSrc == 2'd3 && m_ras.size() > 0) begin
          if (Call) m_ras[m_ras.size()-1] = pc4;
          else void'(m_ras.pop_back());
        end else if (Call) begin
          if (Ret && PCSrc == 2'd3) m_uflow = 1'b1;
          m_ras.push_back(pc4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end else if (Ret && PCSrc == 2'd3) begin
          m_uflow = 1'b1;
        end
        m_pc = tgt;
      end
    end
  endtask

  task automatic defaults();
    Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'd0; Branch_Imm = '0; Jump_Addr = '0;
    Reg_Target = '0; Call = 1'b0; Ret = 1'b0; Trap = 1'b0; Halt = 1'b0; Resume = 1'b0;
  endtask

  // One clock: update the model, let the edge pass, compare all outputs.
  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    check("IAddr", IAddr, m_pc);
    check("PC4", PC4, m_pc + 32'd4);
    check("EPC", EPC, m_epc);
    check("Halted", {31'd0, Halted}, {31'd0, m_halted});
    check("RAS_Count", {29'd0, RAS_Count}, 32'(m_ras.size()));
    check("RAS_Underflow", {31'd0, RAS_Underflow}, {31'd0, m_uflow});
  endtask

  task automatic do_reset();
    defaults(); Reset = 1'b0; step(); Reset = 1'b1;
  endtask

  task automatic go(input logic [31:0] addr, input logic call);
    defaults(); PCWre = 1'b1; PCSrc = 2'd3; Reg_Target = addr; Call = call; step();
  endtask

  task automatic ret(input logic [31:0] fallback);
    defaults(); PCWre = 1'b1; PCSrc = 2'd3; Ret = 1'b1; Reg_Target = fallback; step();
  endtask

  initial begin
    logic [31:0] calls[5];
    logic [31:0] rets[4];
    calls = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h400};
    rets  = '{32'h404, 32'h304, 32'h204, 32'h104};

    // Reset then sequential fetch.
    do_reset();
    check("rst_iaddr", IAddr, 32'h0);
    check("rst_cnt", {29'd0, RAS_Count}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      defaults(); PCWre = 1'b1; step();
      check("seq", IAddr, 32'(i * 4));
    end
    check("seq_pc4", PC4, 32'h10);

    // Branch backward and jump into the current 256 MB region.
    go(32'h20, 1'b0);
    defaults(); PCWre = 1'b1; PCSrc = 2'd1; Branch_Imm = -32'sd3; step();
    check("branch", IAddr, 32'h18);
    go(32'h1000_0040, 1'b0);
    defaults(); PCWre = 1'b1; PCSrc = 2'd2; Jump_Addr = 26'h40; step();
    check("jump", IAddr, 32'h1000_0100);

    // RAS overflow wrap and underflow.
    do_reset();
    foreach (calls[i]) begin
      go(calls[i], 1'b0);
      go(32'h1000, 1'b1);
    end
    check("wrap_cnt", {29'd0, RAS_Count}, 32'd4);
    foreach (rets[i]) begin
      ret(32'hBEEF0);
      check("ret", IAddr, rets[i]);
    end
    ret(32'hBEEF0);
    ret(32'hCAFE0);
    check("uflow_tgt", IAddr, 32'hCAFE0);
    check("uflow_flag", {31'd0, RAS_Underflow}, 32'd1);

    // Halt ignores PCWre; resume holds one edge, then advances.
    do_reset();
    defaults(); PCWre = 1'b1; step(); step();
    defaults(); PCWre = 1'b1; Halt = 1'b1; step();
    check("halt_flag", {31'd0, Halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      defaults(); PCWre = 1'b1; Call = 1'b1; step();
      check("halt_hold", IAddr, 32'h8);
    end
    defaults(); Resume = 1'b1; step();
    check("resume_flag", {31'd0, Halted}, 32'd0);
    check("resume_hold", IAddr, 32'h8);
    defaults(); PCWre = 1'b1; step();
    check("resume_adv", IAddr, 32'hC);

    // Trap while halted.
    do_reset();
    go(32'h10, 1'b0);
    go(32'h20, 1'b1);
    defaults(); PCWre = 1'b1; step();
    defaults(); PCWre = 1'b1; Halt = 1'b1; step();
    defaults(); Trap = 1'b1; step();
    check("trap_pc", IAddr, 32'h100);
    check("trap_epc", EPC, 32'h24);
    check("trap_halt", {31'd0, Halted}, 32'd0);
    check("trap_cnt", {29'd0, RAS_Count}, 32'd1);

    // Simultaneous call+return swaps the top entry; reset beats a trap.
    do_reset();
    go(32'h10, 1'b0);
    go(32'h4C, 1'b1);
    go(32'h80, 1'b1);
    defaults(); PCWre = 1'b1; PCSrc = 2'd3; Call = 1'b1; Ret = 1'b1; Reg_Target = 32'hDEAD0; step();
    check("cr_tgt", IAddr, 32'h50);
    check("cr_cnt", {29'd0, RAS_Count}, 32'd2);
    ret(32'hDEAD0);
    check("cr_top", IAddr, 32'h84);
    go(32'h300, 1'b1);
    defaults(); Reset = 1'b0; Trap = 1'b1; step();
    check("mid_rst_pc", IAddr, RV);
    check("mid_rst_epc", EPC, 32'h0);
    check("mid_rst_cnt", {29'd0, RAS_Count}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      defaults();
      Reset      = ($urandom_range(0, 99) != 0);
      PCWre      = ($urandom_range(0, 9) < 8);
      PCSrc      = 2'($urandom);
      Branch_Imm = 32'($urandom_range(0, 63)) - 32'd32;
      Jump_Addr  = 26'($urandom);
      Reg_Target = $urandom & 32'hFFFF_FFFC;
      Call       = ($urandom_range(0, 9) < 3);
      Ret        = ($urandom_range(0, 9) < 4);
      Trap       = ($urandom_range(0, 49) == 0);
      Halt       = ($urandom_range(0, 24) == 0);
      Resume     = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
